// File: rtl/fre_meter_mc_if.sv
// Probe/result bundle for fre_meter_mc; channel k occupies slice k of every per-channel vector.
interface fre_meter_mc_if #(
  parameter int CH_NUM  = 2,
  parameter int CNT_W   = 20,
  parameter int BCD_DIG = 7
);
  logic [CH_NUM-1:0]           fre_hz_i;
  logic [CH_NUM*CNT_W-1:0]     bin_o;
  logic [CH_NUM*4*BCD_DIG-1:0] bcd_o;
  logic [CH_NUM-1:0]           ovf_o;
  logic                        upd_o;
  logic [CH_NUM-1:0]           low_fre_o;

  modport slave  (input fre_hz_i, output bin_o, bcd_o, ovf_o, upd_o, low_fre_o);
  modport master (output fre_hz_i, input bin_o, bcd_o, ovf_o, upd_o, low_fre_o);
endinterface

// File: rtl/fre_meter_mc.sv
// Multi-channel gated edge counter with a shared round-robin binary-to-BCD converter.
// Optional low-frequency flags are built only when FRE_LOW_FLAG_EN is defined.
module fre_meter_mc_ch #(
  parameter int CNT_W = 20
`ifdef FRE_LOW_FLAG_EN
  , parameter int LOW_THRESH = 1000
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fre_hz_i,
  input  logic             gate_end_i,
  output logic [CNT_W-1:0] bin_o,
  output logic             ovf_o,
  output logic             low_o
);
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, bin_q;
  logic             sovf_q, sovf_d, ovf_q;
  logic             edge_w;

  assign edge_w = sync_q[1] & ~sync_q[2];

  // An edge coincident with gate_end belongs to the window that is just opening.
  always_comb begin
    cnt_d  = cnt_q;
    sovf_d = sovf_q;
    if (gate_end_i) begin
      cnt_d  = CNT_W'(edge_w);
      sovf_d = 1'b0;
    end else if (edge_w) begin
      if (&cnt_q) sovf_d = 1'b1;
      else        cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      sovf_q <= 1'b0;
      bin_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], fre_hz_i};
      cnt_q  <= cnt_d;
      sovf_q <= sovf_d;
      if (gate_end_i) begin
        bin_q <= cnt_q;
        ovf_q <= sovf_q;
      end
    end
  end

  assign bin_o = bin_q;
  assign ovf_o = ovf_q;

`ifdef FRE_LOW_FLAG_EN
  logic low_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)           low_q <= 1'b0;
    else if (gate_end_i) low_q <= (32'(cnt_q) < LOW_THRESH) & ~sovf_q;
  end
  assign low_o = low_q;
`else
  assign low_o = 1'b0;
`endif
endmodule

module fre_meter_mc #(
  parameter int CH_NUM      = 2,
  parameter int CNT_W       = 20,
  parameter int BCD_DIG     = 7,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int LOW_THRESH  = 1000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fre_meter_mc_if.slave bus
);
  localparam int BCD_W = 4 * BCD_DIG;
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int GT_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int BIT_W = $clog2(CNT_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  if (GATE_CYCLES <= CH_NUM * (CNT_W + 2) + 2 || LOW_THRESH < 0) begin : g_param_chk
    $error("fre_meter_mc: gate window shorter than one conversion round, or negative LOW_THRESH");
  end

  logic [GT_W-1:0] gate_q, gate_d;
  logic            gate_end;

  assign gate_end = (gate_q == GT_W'(GATE_CYCLES - 1));
  assign gate_d   = gate_end ? '0 : gate_q + GT_W'(1);

  logic [CH_NUM-1:0][CNT_W-1:0] bin_w;
  logic [CH_NUM-1:0]            ovf_w, low_w;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    fre_meter_mc_ch #(
      .CNT_W(CNT_W)
`ifdef FRE_LOW_FLAG_EN
      , .LOW_THRESH(LOW_THRESH)
`endif
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .fre_hz_i   (bus.fre_hz_i[k]),
      .gate_end_i (gate_end),
      .bin_o      (bin_w[k]),
      .ovf_o      (ovf_w[k]),
      .low_o      (low_w[k])
    );
  end

  logic [2:0]                   state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [CNT_W-1:0]             sr_q, sr_d;
  logic [BCD_W-1:0]             acc_q, acc_d, acc_adj;
  logic [BIT_W-1:0]             bit_q, bit_d;
  logic [CH_NUM-1:0][BCD_W-1:0] bcd_q, bcd_d;
  logic                         upd_q, upd_d;

  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < BCD_DIG; d++)
      if (acc_q[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
  end

  // Conversion works from the latched snapshot, so a new gate_end never disturbs it.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    bcd_d   = bcd_q;
    upd_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ch_d = '0;
        if (gate_end) state_d = S_LOAD;
      end
      S_LOAD: begin
        sr_d    = bin_w[ch_q];
        acc_d   = '0;
        bit_d   = BIT_W'(CNT_W);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {acc_d, sr_d} = {acc_adj, sr_q} << 1;
        bit_d = bit_q - BIT_W'(1);
        if (bit_q == BIT_W'(1)) state_d = S_STORE;
      end
      S_STORE: begin
        bcd_d[ch_q] = ovf_w[ch_q] ? {BCD_DIG{4'h9}} : acc_q;
        state_d     = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == CH_W'(CH_NUM - 1)) begin
          state_d = S_IDLE;
          upd_d   = 1'b1;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate_q  <= '0;
      state_q <= S_IDLE;
      ch_q    <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      bcd_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      gate_q  <= gate_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      bcd_q   <= bcd_d;
      upd_q   <= upd_d;
    end
  end

  assign bus.bin_o     = bin_w;
  assign bus.ovf_o     = ovf_w;
  assign bus.low_fre_o = low_w;
  assign bus.bcd_o     = bcd_q;
  assign bus.upd_o     = upd_q;
endmodule

// File: tb/tb_fre_meter_mc.sv
// Randomised/directed bench for fre_meter_mc against a window-counting reference model.
module tb_fre_meter_mc;
  localparam int CH = 2, W = 8, DIG = 3, GATE = 600, LOW = 50, MAXC = 255;
`ifdef FRE_LOW_FLAG_EN
  localparam bit LOW_EN = 1'b1;
`else
  localparam bit LOW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fre_meter_mc_if #(.CH_NUM(CH), .CNT_W(W), .BCD_DIG(DIG)) bus ();

  fre_meter_mc #(
    .CH_NUM(CH), .CNT_W(W), .BCD_DIG(DIG), .GATE_CYCLES(GATE), .LOW_THRESH(LOW)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0, n_err = 0;
  int k = -1;
  int per [CH] = '{0, 0};   // 0 idle, >0 square-wave period, -1 random level per cycle
  int ph  [CH] = '{0, 0};
  int pulse_k = -10, rst_k = -10, rst_hold = 3;
  bit seen_rst = 1'b0;
  int upd_seen = 0;

  // Reference model state: recent pin levels and raw (unbounded) window edge counts.
  bit          pin_h [CH][4];
  int          win   [CH];
  int          e_bin [CH];
  bit          e_ovf [CH], e_low [CH];
  logic [11:0] pend  [CH], e_bcd [CH];
  bit          e_upd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, k);
    end
  endtask

  function automatic logic [11:0] to_bcd(int v, bit ovf);
    if (ovf) return 12'h999;
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(logic [CH-1:0] p, bit r);
    bit ev;
    if (r) begin
      k = -1; seen_rst = 1'b1; e_upd = 1'b0;
      for (int c = 0; c < CH; c++) begin
        for (int j = 0; j < 4; j++) pin_h[c][j] = 1'b0;
        win[c] = 0; e_bin[c] = 0; e_ovf[c] = 0; e_low[c] = 0;
        pend[c] = '0; e_bcd[c] = '0; ph[c] = 0;
      end
      return;
    end
    k++;
    e_upd = (k % GATE == 21) && (k >= GATE + 21);
    for (int c = 0; c < CH; c++) begin
      pin_h[c][3] = pin_h[c][2];
      pin_h[c][2] = pin_h[c][1];
      pin_h[c][1] = pin_h[c][0];
      pin_h[c][0] = p[c];
      ev = pin_h[c][2] && !pin_h[c][3];   // pin rise two samples ago reaches the counter now
      if (k % GATE == GATE - 1) begin
        e_ovf[c] = (win[c] > MAXC);
        e_bin[c] = e_ovf[c] ? MAXC : win[c];
        e_low[c] = LOW_EN && (e_bin[c] < LOW) && !e_ovf[c];
        pend[c]  = to_bcd(e_bin[c], e_ovf[c]);
        win[c]   = int'(ev);
      end else begin
        win[c] += int'(ev);
      end
      if ((k % GATE == 9 + 11 * c) && (k >= GATE + 9 + 11 * c)) e_bcd[c] = pend[c];
    end
  endtask

  task automatic compare();
    logic [CH*W-1:0]  xb;
    logic [CH*12-1:0] xd;
    logic [CH-1:0]    xo, xl;
    for (int c = 0; c < CH; c++) begin
      xb[c*W +: W]   = W'(e_bin[c]);
      xd[c*12 +: 12] = e_bcd[c];
      xo[c]          = e_ovf[c];
      xl[c]          = e_low[c];
    end
    chk("bin_o",     32'(bus.bin_o),     32'(xb));
    chk("bcd_o",     32'(bus.bcd_o),     32'(xd));
    chk("ovf_o",     32'(bus.ovf_o),     32'(xo));
    chk("low_fre_o", 32'(bus.low_fre_o), 32'(xl));
    chk("upd_o",     32'(bus.upd_o),     32'(e_upd));
    if (bus.upd_o === 1'b1) upd_seen++;
  endtask

  task automatic drive();
    logic [CH-1:0] nx;
    for (int c = 0; c < CH; c++) begin
      ph[c]++;
      if (per[c] > 0)      nx[c] = (ph[c] % per[c]) < per[c] / 2;
      else if (per[c] < 0) nx[c] = 1'($urandom_range(0, 1));
      else                 nx[c] = 1'b0;
    end
    if (k + 1 == pulse_k) nx[0] = 1'b1;
    bus.fre_hz_i = nx;
    if (k >= 0 && k + 1 == rst_k) rst_hold = 1;
    rst = (rst_hold > 0);
    if (rst_hold > 0) rst_hold--;
  endtask

  // Single sampling/model/drive process: capture at the edge, check 1 after, drive 2 after.
  initial begin
    logic [CH-1:0] p;
    bit            r;
    bus.fre_hz_i = '0;
    forever begin
      @(posedge clk);
      p = bus.fre_hz_i;
      r = rst;
      #1;
      model_step(p, r);
      compare();
      #1;
      drive();
    end
  end

  task automatic wait_k(int t);
    while (k < t) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", k);
    $fatal(1, "watchdog");
  end

  initial begin
    // ch0 period 10, ch1 idle
    per[0] = 10;
    wait_k(1230);
    chk("A bin0",   32'(bus.bin_o[7:0]),  32'd60);
    chk("A bcd0",   32'(bus.bcd_o[11:0]), 32'h060);
    chk("A bin1",   32'(bus.bin_o[15:8]), 32'd0);
    chk("A upd#",   32'(upd_seen),        32'd2);
    chk("A model",  32'(e_bin[0]),        32'd60);

    // ch1 period 2 saturates
    per[1] = 2;
    wait_k(2430);
    chk("B bin1",   32'(bus.bin_o[15:8]),  32'd255);
    chk("B ovf",    32'(bus.ovf_o),        32'b10);
    chk("B bcd1",   32'(bus.bcd_o[23:12]), 32'h999);
    chk("B bin0",   32'(bus.bin_o[7:0]),   32'd60);
    chk("B bcd0",   32'(bus.bcd_o[11:0]),  32'h060);

    // both idle, then ch0 at 150 edges per window
    per[0] = 0; per[1] = 0;
    wait_k(3630);
    chk("C bin",    32'(bus.bin_o),     32'd0);
    chk("C bcd",    32'(bus.bcd_o),     32'd0);
    chk("C ovf",    32'(bus.ovf_o),     32'd0);
    chk("C low",    32'(bus.low_fre_o), LOW_EN ? 32'b11 : 32'b00);
    per[0] = 4;
    wait_k(4830);
    chk("C bin0",   32'(bus.bin_o[7:0]),  32'd150);
    chk("C bcd0",   32'(bus.bcd_o[11:0]), 32'h150);
    chk("C low2",   32'(bus.low_fre_o),   LOW_EN ? 32'b10 : 32'b00);

    // one edge landing exactly on gate_end (cycle 5999) belongs to the next window
    per[0] = 0;
    pulse_k = 5997;
    wait_k(6010);
    chk("D bin0 cur",  32'(bus.bin_o[7:0]),  32'd0);
    wait_k(6610);
    chk("D bin0 next", 32'(bus.bin_o[7:0]),  32'd1);
    wait_k(6630);
    chk("D bcd0 next", 32'(bus.bcd_o[11:0]), 32'h001);

    // random traffic
    per[0] = -1;
    per[1] = int'($urandom_range(2, 13));
    wait_k(7830);
    per[1] = int'($urandom_range(2, 13));
    wait_k(8700);

    // reset during ch1 SHIFT of the conversion after gate_end 8999
    per[0] = 10; per[1] = 0;
    seen_rst = 1'b0;
    rst_k = 9014;
    while (!seen_rst) @(negedge clk);
    rst_k = -10;
    upd_seen = 0;
    chk("F rst bin", 32'(bus.bin_o), 32'd0);
    chk("F rst bcd", 32'(bus.bcd_o), 32'd0);
    chk("F rst upd", 32'(bus.upd_o), 32'd0);
    wait_k(1830);
    chk("F bin0",   32'(bus.bin_o[7:0]),  32'd60);
    chk("F bcd0",   32'(bus.bcd_o[11:0]), 32'h060);
    chk("F upd#",   32'(upd_seen),        32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
